// File: rtl/ysyx_22051086_ex_commit_buf.sv
// ysyx_22051086_ex_commit_buf
//   EX->MEM boundary stage sitting directly after the ALU. It forwards the EX
//   valid to the ALU, holds EX while the ALU reports a multi-cycle op, and
//   captures the final result plus the instruction sideband into a 2-entry
//   skid buffer (head + skid). MEM back-pressure therefore reaches ID/EX only
//   through registered state. *W results are sign-extended from bit 31, and
//   cycles spent waiting on a busy ALU are counted in a saturating counter.
//
// Ports
//   clk, rst (async, active-low), flush
//   ex_*          : instruction entering from ID/EX (valid/ready handshake)
//   alu_ex_valid  : valid toward the ALU; alu_res / alu_busy back from it
//   mem_*         : head entry toward MEM (mem_valid/mem_ready handshake)
//   stall_cnt     : saturating count of cycles with ex_valid_in && alu_busy
//
// Optional feature (macro YSYX_22051086_EX_FWD_EN)
//   Adds fwd_valid / fwd_rd / fwd_data giving the youngest buffered entry
//   that writes a non-zero register. Without the macro the ports and the
//   forwarding logic do not exist.
module ysyx_22051086_ex_commit_buf #(
  parameter int XLEN   = 64,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid_in,
  output logic              ex_ready_out,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_rd_wen,
  input  logic              ex_word,
  input  logic [CTRL_W-1:0] ex_mem_ctrl,
  input  logic [XLEN-1:0]   ex_store_data,
  output logic              alu_ex_valid,
  input  logic [XLEN-1:0]   alu_res,
  input  logic              alu_busy,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_pc,
  output logic [RD_W-1:0]   mem_rd,
  output logic              mem_rd_wen,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [XLEN-1:0]   mem_alu_res,
  output logic [XLEN-1:0]   mem_store_data,
  output logic [31:0]       stall_cnt
`ifdef YSYX_22051086_EX_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [XLEN-1:0]   fwd_data
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [RD_W-1:0]   rd;
    logic              rd_wen;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   res;
    logic [XLEN-1:0]   store_data;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_reg, state_next;
  entry_t head_reg, skid_reg, new_entry;
  logic [31:0] stall_cnt_reg;

  logic push, pop;
  logic head_load_new, head_load_skid, skid_load;

  assign alu_ex_valid = ex_valid_in & ~flush;
  assign ex_ready_out = ~alu_busy & (state_reg != FULL) & ~flush;
  assign push         = ex_valid_in & ex_ready_out;
  assign mem_valid    = (state_reg != EMPTY);
  assign pop          = mem_valid & mem_ready;

  always_comb begin
    new_entry.pc         = ex_pc;
    new_entry.rd         = ex_rd;
    new_entry.rd_wen     = ex_rd_wen;
    new_entry.ctrl       = ex_mem_ctrl;
    new_entry.res        = ex_word ? {{(XLEN-32){alu_res[31]}}, alu_res[31:0]} : alu_res;
    new_entry.store_data = ex_store_data;
  end

  // Next-state and buffer-load decode. push already excludes flush through
  // ex_ready_out, so flush only needs to override the state transition.
  always_comb begin
    state_next     = state_reg;
    head_load_new  = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            state_next    = ONE;
            head_load_new = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_next = FULL;
            skid_load  = 1'b1;
          end else if (push && pop) begin
            head_load_new = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_next     = ONE;
            head_load_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (head_load_new) begin
        head_reg <= new_entry;
      end else if (head_load_skid) begin
        head_reg <= skid_reg;
      end
      if (skid_load) begin
        skid_reg <= new_entry;
      end
    end
  end

  // Stall counter survives flush; it only measures ALU wait time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (ex_valid_in && alu_busy && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt      = stall_cnt_reg;
  assign mem_pc         = head_reg.pc;
  assign mem_rd         = head_reg.rd;
  assign mem_rd_wen     = head_reg.rd_wen;
  assign mem_ctrl       = head_reg.ctrl;
  assign mem_alu_res    = head_reg.res;
  assign mem_store_data = head_reg.store_data;

`ifdef YSYX_22051086_EX_FWD_EN
  // Decoded purely from buffer registers: the skid entry is younger than the
  // head, so it wins when it qualifies; otherwise fall back to the head.
  logic skid_fwd_ok, head_fwd_ok;
  assign skid_fwd_ok = (state_reg == FULL) && skid_reg.rd_wen && (skid_reg.rd != '0);
  assign head_fwd_ok = (state_reg != EMPTY) && head_reg.rd_wen && (head_reg.rd != '0);

  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    if (skid_fwd_ok) begin
      fwd_valid = 1'b1;
      fwd_rd    = skid_reg.rd;
      fwd_data  = skid_reg.res;
    end else if (head_fwd_ok) begin
      fwd_valid = 1'b1;
      fwd_rd    = head_reg.rd;
      fwd_data  = head_reg.res;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22051086_ex_commit_buf.sv
module tb_ysyx_22051086_ex_commit_buf;

  localparam int XLEN = 64;
  localparam int RD_W = 5;
  localparam int CTRL_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              ex_valid_in;
  logic              ex_ready_out;
  logic [XLEN-1:0]   ex_pc;
  logic [RD_W-1:0]   ex_rd;
  logic              ex_rd_wen;
  logic              ex_word;
  logic [CTRL_W-1:0] ex_mem_ctrl;
  logic [XLEN-1:0]   ex_store_data;
  logic              alu_ex_valid;
  logic [XLEN-1:0]   alu_res;
  logic              alu_busy;
  logic              mem_valid;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_pc;
  logic [RD_W-1:0]   mem_rd;
  logic              mem_rd_wen;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [XLEN-1:0]   mem_alu_res;
  logic [XLEN-1:0]   mem_store_data;
  logic [31:0]       stall_cnt;
`ifdef YSYX_22051086_EX_FWD_EN
  logic              fwd_valid;
  logic [RD_W-1:0]   fwd_rd;
  logic [XLEN-1:0]   fwd_data;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_22051086_ex_commit_buf #(.XLEN(XLEN), .RD_W(RD_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid_in(ex_valid_in), .ex_ready_out(ex_ready_out),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen), .ex_word(ex_word),
    .ex_mem_ctrl(ex_mem_ctrl), .ex_store_data(ex_store_data),
    .alu_ex_valid(alu_ex_valid), .alu_res(alu_res), .alu_busy(alu_busy),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_rd_wen(mem_rd_wen), .mem_ctrl(mem_ctrl),
    .mem_alu_res(mem_alu_res), .mem_store_data(mem_store_data),
    .stall_cnt(stall_cnt)
`ifdef YSYX_22051086_EX_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic        busy;
    logic        word;
    logic [63:0] res;
    logic        mready;
    logic        exp_ready;
    logic        exp_mvalid;
    logic [63:0] exp_res;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Streaming: one accepted per cycle, result visible the next cycle
    vecs[0]  = '{1, 0, 0, 64'h4,  1, 1, 1, 64'h4};
    vecs[1]  = '{1, 0, 0, 64'h8,  1, 1, 1, 64'h8};
    vecs[2]  = '{1, 0, 0, 64'hC,  1, 1, 1, 64'hC};
    // Backpressure: second entry goes to skid, third is refused while FULL
    vecs[3]  = '{1, 0, 0, 64'h10, 0, 1, 1, 64'hC};
    vecs[4]  = '{1, 0, 0, 64'h14, 0, 0, 1, 64'hC};
    vecs[5]  = '{1, 0, 0, 64'h14, 0, 0, 1, 64'hC};
    vecs[6]  = '{1, 0, 0, 64'h14, 1, 0, 1, 64'h10};
    vecs[7]  = '{1, 0, 0, 64'h14, 0, 1, 1, 64'h10};
    vecs[8]  = '{0, 0, 0, 64'h0,  1, 0, 1, 64'h14};
    vecs[9]  = '{0, 0, 0, 64'h0,  1, 1, 0, 64'h0};
    // Word ops sign-extend bit 31; non-word passes through
    vecs[10] = '{1, 0, 1, 64'h0000_0000_8000_0000, 1, 1, 1, 64'hFFFF_FFFF_8000_0000};
    vecs[11] = '{1, 0, 1, 64'h1234_5678_7FFF_FFFF, 1, 1, 1, 64'h0000_0000_7FFF_FFFF};
    vecs[12] = '{1, 0, 0, 64'hDEAD_BEEF_0000_0001, 1, 1, 1, 64'hDEAD_BEEF_0000_0001};
    // Busy ALU blocks the push while the head drains
    vecs[13] = '{1, 1, 0, 64'h55, 1, 0, 0, 64'h0};
    vecs[14] = '{0, 0, 0, 64'h0,  1, 1, 0, 64'h0};

    // ---- Reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flush = $urandom_range(0, 1); ex_valid_in = 1'b1; alu_busy = 1'b1;
      ex_pc = {$urandom, $urandom}; ex_rd = 5'($urandom); ex_rd_wen = 1'b1;
      ex_word = $urandom_range(0, 1); ex_mem_ctrl = 8'($urandom);
      ex_store_data = {$urandom, $urandom}; alu_res = {$urandom, $urandom};
      mem_ready = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
    chk("rst_mem_valid", 64'(mem_valid), 64'h0);
    chk("rst_mem_res", mem_alu_res, 64'h0);
    chk("rst_mem_pc", mem_pc, 64'h0);
    chk("rst_mem_rd", 64'(mem_rd), 64'h0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    flush = 0; ex_valid_in = 0; alu_busy = 0; ex_word = 0; mem_ready = 1;
    ex_rd = 5'd1; ex_rd_wen = 1'b1; ex_mem_ctrl = 8'h0; ex_store_data = 64'h0;
    alu_res = 64'h0; ex_pc = 64'h0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_mem_valid", 64'(mem_valid), 64'h0);
    chk("post_rst_stall_cnt", 64'(stall_cnt), 64'h0);

    // ---- DIV-style stall: 33 busy cycles then result 7
    ex_valid_in = 1; alu_busy = 1; ex_pc = 64'h100; alu_res = 64'h0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      chk($sformatf("div_ready_%0d", i), 64'(ex_ready_out), 64'h0);
      @(posedge clk); #1;
    end
    chk("div_alu_ex_valid", 64'(alu_ex_valid), 64'h1);
    alu_busy = 0; alu_res = 64'h7;
    @(negedge clk);
    chk("div_ready_done", 64'(ex_ready_out), 64'h1);
    @(posedge clk); #1;
    chk("div_mem_valid", 64'(mem_valid), 64'h1);
    chk("div_mem_res", mem_alu_res, 64'h7);
    chk("div_mem_pc", mem_pc, 64'h100);
    chk("div_stall_cnt", 64'(stall_cnt), 64'd33);
    ex_valid_in = 0;
    @(posedge clk); #1;
    chk("div_single_entry", 64'(mem_valid), 64'h0);

    // ---- Table-driven streaming / backpressure / word / busy
    for (int i = 0; i < 15; i++) begin
      ex_valid_in = vecs[i].valid; alu_busy = vecs[i].busy; ex_word = vecs[i].word;
      alu_res = vecs[i].res; ex_pc = vecs[i].res - 64'd4; mem_ready = vecs[i].mready;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 64'(ex_ready_out), 64'(vecs[i].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_mem_valid", i), 64'(mem_valid), 64'(vecs[i].exp_mvalid));
      if (vecs[i].exp_mvalid)
        chk($sformatf("vec%0d_mem_res", i), mem_alu_res, vecs[i].exp_res);
    end

    // ---- Flush while FULL with a push pending
    ex_word = 0; alu_busy = 0; mem_ready = 0; ex_valid_in = 1;
    ex_rd = 5'd3; alu_res = 64'hA0; ex_pc = 64'h200;
    @(posedge clk); #1;
    ex_rd = 5'd7; alu_res = 64'hB0; ex_pc = 64'h204;
    @(posedge clk); #1;
    chk("full_mem_valid", 64'(mem_valid), 64'h1);
    chk("full_head_res", mem_alu_res, 64'hA0);
    chk("full_head_rd", 64'(mem_rd), 64'd3);
`ifdef YSYX_22051086_EX_FWD_EN
    chk("full_fwd_valid", 64'(fwd_valid), 64'h1);
    chk("full_fwd_rd", 64'(fwd_rd), 64'd7);
    chk("full_fwd_data", fwd_data, 64'hB0);
`endif
    ex_rd = 5'd9; alu_res = 64'hC0; ex_pc = 64'h208; flush = 1;
    @(negedge clk);
    chk("flush_ready", 64'(ex_ready_out), 64'h0);
    chk("flush_alu_ex_valid", 64'(alu_ex_valid), 64'h0);
    @(posedge clk); #1;
    chk("flush_mem_valid", 64'(mem_valid), 64'h0);
`ifdef YSYX_22051086_EX_FWD_EN
    chk("flush_fwd_valid", 64'(fwd_valid), 64'h0);
`endif
    flush = 0; ex_valid_in = 0;
    @(posedge clk); #1;
    chk("after_flush_mem_valid", 64'(mem_valid), 64'h0);
    chk("final_stall_cnt", 64'(stall_cnt), 64'd34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
